// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and constants for the CPU run controller
// Purpose: run-state encoding, stop-cause codes, pipeline NOP and default halt opcode.
// Ports:   none (package).
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } run_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'b00,
      CAUSE_HALT  = 2'b01,
      CAUSE_LIMIT = 2'b10,
      CAUSE_ABORT = 2'b11
   } stop_cause_t;

   // addi x0, x0, 0 -- what the integration muxes into IF/ID while squashing
   localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
   // SYSTEM opcode (ecall/ebreak) requests a halt
   localparam logic [6:0]  HALT_OPCODE_DEF = 7'h73;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - host/core-side signal bundle of the CPU run controller
// Purpose: groups run control, IF-stage snoop and host memory strobes.
// Ports:   slave  = controller view (inputs: start, abort, cycle_limit, instruction_if, *_req;
//                   outputs: cpu_enable, if_squash, gated strobes, busy, done, stop_cause,
//                   cycle_count, host_blocked)
//          master = host view (directions reversed)
interface cpu_run_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] cycle_limit;
   logic [31:0]      instruction_if;
   logic             wen_ext_req;
   logic             ren_ext_req;
   logic             wen_ext_2_req;
   logic             ren_ext_2_req;
   logic             cpu_enable;
   logic             if_squash;
   logic             wen_ext;
   logic             ren_ext;
   logic             wen_ext_2;
   logic             ren_ext_2;
   logic             busy;
   logic             done;
   logic [1:0]       stop_cause;
   logic [CNT_W-1:0] cycle_count;
   logic             host_blocked;

   modport slave (
      input  start, abort, cycle_limit, instruction_if,
      input  wen_ext_req, ren_ext_req, wen_ext_2_req, ren_ext_2_req,
      output cpu_enable, if_squash, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
      output busy, done, stop_cause, cycle_count, host_blocked
   );

   modport master (
      output start, abort, cycle_limit, instruction_if,
      output wen_ext_req, ren_ext_req, wen_ext_2_req, ren_ext_2_req,
      input  cpu_enable, if_squash, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
      input  busy, done, stop_cause, cycle_count, host_blocked
   );
endinterface

// File: rtl/run_cycle_counter.sv
// rtl/run_cycle_counter.sv - saturating cycle counter with synchronous clear
// Purpose: counts enabled core cycles; sticks at all-ones instead of wrapping.
// Ports:   clk, arst_n (async active-low), i_clr (sync clear, wins over i_inc),
//          i_inc (count enable), o_count (registered count).
module run_cycle_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;
endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run controller sequencing start, halt/limit/abort and pipeline drain
// Purpose: drives the core enable, squashes fetch while draining, gates host memory
//          strobes while the core runs and counts enabled cycles.
// Ports:   clk, arst_n (async active-low), bus (cpu_run_ctrl_if.slave, see interface).
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int         CNT_W        = 32,
   parameter int         DRAIN_CYCLES = 4,
   parameter logic [6:0] HALT_OPCODE  = HALT_OPCODE_DEF
) (
   input  logic          clk,
   input  logic          arst_n,
   cpu_run_ctrl_if.slave bus
);
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   run_state_t       r_state;
   stop_cause_t      r_stop_cause;
   logic             r_cpu_enable;
   logic             r_if_squash;
   logic             r_busy;
   logic             r_done;
   logic [DRAIN_W-1:0] r_drain;

   logic [CNT_W-1:0] w_count;
   logic             w_clr;
   logic             w_halt;
   logic             w_limit_hit;
   logic             w_host_lock;
   logic             w_unused_instr;

   // Only the opcode field of the IF word matters here
   assign w_unused_instr = ^bus.instruction_if[31:7];

   assign w_clr       = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.start;
   assign w_halt      = (bus.instruction_if[6:0] == HALT_OPCODE);
   // Compare against the count after this cycle so the run lasts exactly cycle_limit cycles
   assign w_limit_hit = (bus.cycle_limit != '0) &&
                        ((w_count + CNT_W'(1)) == bus.cycle_limit);

   run_cycle_counter #(.CNT_W(CNT_W)) u_cycle_counter (
      .clk     (clk),
      .arst_n  (arst_n),
      .i_clr   (w_clr),
      .i_inc   (r_cpu_enable),
      .o_count (w_count)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state      <= ST_IDLE;
         r_stop_cause <= CAUSE_NONE;
         r_cpu_enable <= 1'b0;
         r_if_squash  <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_drain      <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  r_state      <= ST_RUN;
                  r_stop_cause <= CAUSE_NONE;
                  r_cpu_enable <= 1'b1;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
               end
            end
            ST_RUN: begin
               if (bus.abort) begin
                  // Abort freezes the pipeline as-is; no drain
                  r_state      <= ST_DONE;
                  r_stop_cause <= CAUSE_ABORT;
                  r_cpu_enable <= 1'b0;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
               end else if (w_halt || w_limit_hit) begin
                  r_state      <= ST_DRAIN;
                  r_stop_cause <= w_halt ? CAUSE_HALT : CAUSE_LIMIT;
                  r_if_squash  <= 1'b1;
                  r_drain      <= DRAIN_W'(DRAIN_CYCLES - 1);
               end
            end
            ST_DRAIN: begin
               if (bus.abort || (r_drain == '0)) begin
                  r_state      <= ST_DONE;
                  r_cpu_enable <= 1'b0;
                  r_if_squash  <= 1'b0;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
                  if (bus.abort) begin
                     r_stop_cause <= CAUSE_ABORT;
                  end
               end else begin
                  r_drain <= r_drain - DRAIN_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.cpu_enable  = r_cpu_enable;
   assign bus.if_squash   = r_if_squash;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.stop_cause  = r_stop_cause;
   assign bus.cycle_count = w_count;

   // Host strobes are decoded from state directly so the gate is exact on the first RUN cycle
   assign w_host_lock      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign bus.wen_ext      = bus.wen_ext_req   & ~w_host_lock;
   assign bus.ren_ext      = bus.ren_ext_req   & ~w_host_lock;
   assign bus.wen_ext_2    = bus.wen_ext_2_req & ~w_host_lock;
   assign bus.ren_ext_2    = bus.ren_ext_2_req & ~w_host_lock;
   assign bus.host_blocked = w_host_lock &
                             (bus.wen_ext_req | bus.ren_ext_req |
                              bus.wen_ext_2_req | bus.ren_ext_2_req);
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;
   import cpu_ctrl_pkg::*;

   localparam logic [31:0] HALT_WORD = 32'h0000_0073;

   typedef struct {
      logic [1:0] cause;
      int         count;
      int         en;
      int         sq;
   } exp_t;

   logic  clk;
   logic  arst_n;
   int    n_tests;
   int    n_fail;
   exp_t  sb_q[$];

   cpu_run_ctrl_if #(.CNT_W(32)) bus ();

   cpu_run_ctrl #(
      .CNT_W        (32),
      .DRAIN_CYCLES (4),
      .HALT_OPCODE  (7'h73)
   ) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // One full run from IDLE/DONE; expectations are queued when stimulus starts
   // and popped once the controller reports done.
   task automatic run_case(input string tag, input logic [31:0] limit, input int halt_cyc,
                           input int abort_cyc, input logic [1:0] e_cause,
                           input int e_count, input int e_sq);
      exp_t e;
      int   en;
      int   sq;
      bit   ok;
      e.cause = e_cause;
      e.count = e_count;
      e.en    = e_count;
      e.sq    = e_sq;
      sb_q.push_back(e);

      bus.cycle_limit = limit;
      bus.start       = 1'b1;
      tick();
      bus.start = 1'b0;
      check_eq({tag, "_start_en"}, 64'(bus.cpu_enable), 64'd1);
      check_eq({tag, "_start_busy"}, 64'(bus.busy), 64'd1);

      en = 0;
      sq = 0;
      ok = 1'b0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
         en += int'(bus.cpu_enable);
         sq += int'(bus.if_squash);
         bus.instruction_if = (cyc == halt_cyc) ? HALT_WORD : NOP_INSTR;
         bus.abort          = (cyc == abort_cyc);
         tick();
      end
      bus.instruction_if = NOP_INSTR;
      bus.abort          = 1'b0;
      check_eq({tag, "_done_reached"}, 64'(ok), 64'd1);

      e = sb_q.pop_front();
      check_eq({tag, "_cause"}, 64'(bus.stop_cause), 64'(e.cause));
      check_eq({tag, "_count"}, 64'(bus.cycle_count), 64'(e.count));
      check_eq({tag, "_en_cycles"}, 64'(en), 64'(e.en));
      check_eq({tag, "_squash_cycles"}, 64'(sq), 64'(e.sq));
      check_eq({tag, "_cpu_enable_off"}, 64'(bus.cpu_enable), 64'd0);

      // DONE holds cause and count until the next start
      repeat (3) tick();
      check_eq({tag, "_hold_cause"}, 64'(bus.stop_cause), 64'(e.cause));
      check_eq({tag, "_hold_count"}, 64'(bus.cycle_count), 64'(e.count));
      check_eq({tag, "_hold_done"}, 64'(bus.done), 64'd1);
   endtask

   initial begin
      n_tests            = 0;
      n_fail             = 0;
      arst_n             = 1'b0;
      bus.start          = 1'b0;
      bus.abort          = 1'b0;
      bus.cycle_limit    = '0;
      bus.instruction_if = NOP_INSTR;
      bus.wen_ext_req    = 1'b0;
      bus.ren_ext_req    = 1'b0;
      bus.wen_ext_2_req  = 1'b0;
      bus.ren_ext_2_req  = 1'b0;

      repeat (2) tick();
      check_eq("rst_cpu_enable", 64'(bus.cpu_enable), 64'd0);
      check_eq("rst_if_squash", 64'(bus.if_squash), 64'd0);
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_done", 64'(bus.done), 64'd0);
      check_eq("rst_stop_cause", 64'(bus.stop_cause), 64'd0);
      check_eq("rst_cycle_count", 64'(bus.cycle_count), 64'd0);
      check_eq("rst_host_blocked", 64'(bus.host_blocked), 64'd0);
      bus.ren_ext_req = 1'b1;
      #1;
      check_eq("idle_ren_pass", 64'(bus.ren_ext), 64'd1);
      check_eq("idle_ren_blocked", 64'(bus.host_blocked), 64'd0);
      bus.ren_ext_req = 1'b0;
      arst_n = 1'b1;
      tick();

      run_case("limit10",      32'd10, 0, 0, 2'b10, 14, 4);
      run_case("halt6",        32'd0,  6, 0, 2'b01, 10, 4);
      run_case("abort_drain",  32'd0,  3, 5, 2'b11, 5,  2);
      run_case("limit1_halt",  32'd1,  1, 0, 2'b01, 5,  4);
      run_case("abort_run",    32'd0,  0, 4, 2'b11, 4,  0);
      run_case("limit3_halt",  32'd3,  3, 0, 2'b01, 7,  4);
      run_case("limit3_abort", 32'd3,  0, 3, 2'b11, 3,  0);

      // Host gating in RUN, then asynchronous reset mid-run
      bus.cycle_limit = '0;
      bus.start       = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      bus.wen_ext_2_req = 1'b1;
      #1;
      check_eq("run_wen2_gated", 64'(bus.wen_ext_2), 64'd0);
      check_eq("run_host_blocked", 64'(bus.host_blocked), 64'd1);
      check_eq("run_count_c5", 64'(bus.cycle_count), 64'd4);
      #1;
      arst_n = 1'b0;
      #1;
      check_eq("arst_cpu_enable", 64'(bus.cpu_enable), 64'd0);
      check_eq("arst_busy", 64'(bus.busy), 64'd0);
      check_eq("arst_cycle_count", 64'(bus.cycle_count), 64'd0);
      check_eq("arst_stop_cause", 64'(bus.stop_cause), 64'd0);
      check_eq("arst_wen2_pass", 64'(bus.wen_ext_2), 64'd1);
      check_eq("arst_host_blocked", 64'(bus.host_blocked), 64'd0);
      tick();
      arst_n            = 1'b1;
      bus.wen_ext_2_req = 1'b0;
      tick();

      // start held high through RUN must not restart the run
      bus.start = 1'b1;
      tick();
      repeat (6) tick();
      check_eq("hold_start_count", 64'(bus.cycle_count), 64'd6);
      check_eq("hold_start_busy", 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check_eq("hold_start_done", 64'(bus.done), 64'd1);
      check_eq("hold_start_cause", 64'(bus.stop_cause), 64'd3);
      check_eq("hold_start_final", 64'(bus.cycle_count), 64'd7);
      bus.wen_ext_2_req = 1'b1;
      #1;
      check_eq("done_wen2_pass", 64'(bus.wen_ext_2), 64'd1);
      check_eq("done_host_blocked", 64'(bus.host_blocked), 64'd0);
      bus.wen_ext_2_req = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the 5-stage RISC-V core. It sequences program execution: start on host command, stop on a halt instruction, a cycle limit or an abort, then drain the pipeline before stopping. It drives the core's global `enable`, squashes fetch during drain and gates host access to both memories while the core runs. It sits between the testbench/host and `cpu`, and counts executed cycles.

## Interface
Parameters:
- `CNT_W`, 32: width of the cycle limit and cycle counter.
- `DRAIN_CYCLES`, 4: enabled cycles after halt detection, so in-flight instructions reach WB.
- `HALT_OPCODE`, 7'h73: IF-stage opcode that requests a halt (SYSTEM/ECALL).

Ports (clock and reset first):
- `clk` in 1: the single clock; all state updates on its rising edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled only in IDLE or DONE.
- `abort` in 1: immediate stop request.
- `cycle_limit` in CNT_W: maximum RUN cycles; 0 means no limit.
- `instruction_if` in 32: instruction memory read data (IF stage).
- `wen_ext_req`, `ren_ext_req`, `wen_ext_2_req`, `ren_ext_2_req` in 1 each: host memory strobes.
- `cpu_enable` out 1: drives `cpu.enable`.
- `if_squash` out 1: integration muxes the IF/ID instruction input to NOP 32'h00000013.
- `wen_ext`, `ren_ext`, `wen_ext_2`, `ren_ext_2` out 1 each: gated host strobes to `cpu`.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: high in DONE.
- `stop_cause` out 2: 00 none, 01 halt, 10 limit, 11 abort.
- `cycle_count` out CNT_W: enabled cycles of the last or current run.
- `host_blocked` out 1: a host strobe was dropped this cycle.

## Operation
- States: IDLE, RUN, DRAIN, DONE. All outputs are registered except the gated strobes and `host_blocked`, which are combinational from the state and the `*_req` inputs.
- IDLE/DONE to RUN:
  - Trigger: `start`=1.
  - On entry: clear `cycle_count`, `stop_cause`=00, `cpu_enable`=1.
  - `start` is ignored in RUN and DRAIN.
- RUN, evaluated each cycle, in priority order:
  1. `abort` goes to DONE with cause 11.
  2. `instruction_if[6:0]`==HALT_OPCODE goes to DRAIN with cause 01.
  3. `cycle_limit`!=0 and `cycle_count`+1==`cycle_limit` goes to DRAIN with cause 10.
- DRAIN:
  - `cpu_enable`=1 and `if_squash`=1.
  - Drain counter loads DRAIN_CYCLES-1 on entry and goes to DONE when it reaches 0.
  - `abort` goes to DONE immediately and overwrites the cause with 11.
- DONE: `cpu_enable`=0, `done`=1; the cause and count hold until the next `start`.
- Abort skips drain: partially executed instructions stay frozen in the pipeline registers.
- `cycle_count` increments on every cycle with `cpu_enable`=1 (RUN and DRAIN) and saturates at all-ones, with no wrap.
- Host gating:
  - In IDLE/DONE, each `*_req` passes straight to its output.
  - In RUN/DRAIN, all gated strobes are 0 and `host_blocked`=|`*_req`.
- No PC or pipeline reset: a restart resumes from the current PC. The host pulses `arst_n` for a fresh program.

## Timing
- Reset values:
  - State IDLE.
  - `cpu_enable`, `if_squash`, `busy`, `done`, `host_blocked` = 0.
  - `stop_cause` = 00, `cycle_count` = 0.
- `start` at edge t: `cpu_enable`=1 and `busy`=1 during cycle t+1.
- Halt seen in RUN at edge t: DRAIN during cycles t+1 .. t+DRAIN_CYCLES, DONE from t+DRAIN_CYCLES+1.
  - With the default, `cycle_count` = RUN cycles + 4.
- Limit L: exactly L RUN cycles, then DRAIN_CYCLES drain; final `cycle_count` = L+DRAIN_CYCLES.
- `abort` at edge t: `cpu_enable`=0 from t+1.
- Halt and limit in the same cycle: the cause is halt. `abort` with either: the cause is abort.
- `arst_n` low mid-run: immediate return to reset values; `cpu_enable` drops asynchronously.

## Structure
- Package `cpu_ctrl_pkg`:
  - state enum;
  - `stop_cause` codes;
  - NOP constant 32'h00000013;
  - default HALT_OPCODE.
- Sub-module `run_cycle_counter`: CNT_W saturating counter with synchronous clear and increment enable, async reset. It is instantiated once; the drain counter is inline.

## Test plan
- Reset, then `start` with `cycle_limit`=10 and no halt word: 10 RUN + 4 DRAIN cycles, then `done`=1, `stop_cause`=10, `cycle_count`=14, `cpu_enable`=0.
- `cycle_limit`=0 and `instruction_if`=32'h00000073 at RUN cycle 6: `if_squash` high for 4 cycles, `stop_cause`=01, `cycle_count`=10.
- `abort` during DRAIN cycle 2 after a halt: DONE next cycle, `stop_cause`=11, no further enabled cycles.
- `wen_ext_2_req`=1 in RUN: `wen_ext_2`=0 and `host_blocked`=1. The same request in DONE passes through with `host_blocked`=0.
- `arst_n` asserted mid-RUN, then `start` held high during RUN: the outputs return to reset values asynchronously, and `start` in RUN has no effect (count continues, no restart).
- `cycle_limit`=1 with a halt word in the same cycle: `stop_cause`=01 and `cycle_count`=5.
